// File: rtl/id_ex_reg.sv
// D->E pipeline register: captures decoded control and operands, inserts bubbles on flush or invalid D.
// Optional bubble counter on BubbleCntE when ID_EX_PERF_EN is defined; otherwise tied to zero.
module id_ex_reg #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EnE,
  input  logic        FlushE,
  input  logic        ValidD,
  input  logic [31:0] InstrD,
  input  logic [31:0] PC8D,
  input  logic [31:0] RD1D,
  input  logic [31:0] RD2D,
  input  logic [31:0] ImmExtD,
  input  logic [4:0]  RsD,
  input  logic [4:0]  RtD,
  input  logic [4:0]  RdD,
  input  logic        RegWriteD,
  input  logic        MemtoRegD,
  input  logic        MemWriteD,
  input  logic        ALUSrcD,
  input  logic        RegDstD,
  input  logic [2:0]  ALUCtrlD,
  output logic        ValidE,
  output logic [31:0] InstrE,
  output logic [31:0] PC8E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [4:0]  RsE,
  output logic [4:0]  RtE,
  output logic [4:0]  RdE,
  output logic        RegWriteE,
  output logic        MemtoRegE,
  output logic        MemWriteE,
  output logic        ALUSrcE,
  output logic        RegDstE,
  output logic [2:0]  ALUCtrlE,
  output logic [4:0]  WriteRegE,
  output logic [1:0]  TnewE,
  output logic [31:0] BubbleCntE
);

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        reg_dst;
    logic [2:0]  alu_ctrl;
  } stage_t;

  stage_t stage;
  stage_t bubble;
  stage_t din;

  always_comb begin
    bubble       = '0;
    bubble.instr = NOP_INSTR;
  end

  always_comb begin
    din.valid      = ValidD;
    din.instr      = InstrD;
    din.pc8        = PC8D;
    din.rd1        = RD1D;
    din.rd2        = RD2D;
    din.imm        = ImmExtD;
    din.rs         = RsD;
    din.rt         = RtD;
    din.rd         = RdD;
    din.reg_write  = RegWriteD;
    din.mem_to_reg = MemtoRegD;
    din.mem_write  = MemWriteD;
    din.alu_src    = ALUSrcD;
    din.reg_dst    = RegDstD;
    din.alu_ctrl   = ALUCtrlD;
  end

  // An invalid D slot is loaded as a bubble so undecoded control never reaches E.
  always_ff @(posedge clk) begin
    if (reset || FlushE)
      stage <= bubble;
    else if (EnE)
      stage <= ValidD ? din : bubble;
  end

  assign ValidE    = stage.valid;
  assign InstrE    = stage.instr;
  assign PC8E      = stage.pc8;
  assign RD1E      = stage.rd1;
  assign RD2E      = stage.rd2;
  assign ImmExtE   = stage.imm;
  assign RsE       = stage.rs;
  assign RtE       = stage.rt;
  assign RdE       = stage.rd;
  assign RegWriteE = stage.reg_write;
  assign MemtoRegE = stage.mem_to_reg;
  assign MemWriteE = stage.mem_write;
  assign ALUSrcE   = stage.alu_src;
  assign RegDstE   = stage.reg_dst;
  assign ALUCtrlE  = stage.alu_ctrl;

  assign WriteRegE = stage.reg_dst ? stage.rd : stage.rt;
  assign TnewE     = stage.mem_to_reg ? 2'd2 : (stage.reg_write ? 2'd1 : 2'd0);

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (FlushE || (EnE && !ValidD))
      bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign BubbleCntE = bubble_cnt;
`else
  assign BubbleCntE = '0;
`endif

endmodule
